mmio_uart_fifo_interface: RTL and testbench

Parametrised MMIO bridge between the core's data-memory port and a UART TX/RX pair. Adds TX and RX FIFOs, a sticky-error status register and a control register. TX drains to the UART through a handshake FSM; RX bytes are buffered for CPU polling. Sits beside data memory and decodes a 16-byte window at BASE_ADDR.

---
 rtl/mmio_uart_fifo_interface_if.sv | 33 +++
 rtl/mmio_uart_fifo_interface.sv | 194 +++++++++++++++++++
 tb/tb_mmio_uart_fifo_interface.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_uart_fifo_interface_if.sv
// CPU data-memory port plus UART TX/RX side signals for the MMIO UART bridge.
// Latency: n/a (signal bundle only).
// Backpressure: n/a; the bridge drops pushes into a full FIFO and flags the overflow.
//
// master: CPU / UART environment side (drives the bus and the UART inputs)
// slave : the bridge (decodes the bus, drives tx byte/start and load data)
interface mmio_uart_fifo_interface_if;
    logic [31:0] data_memory_address;
    logic [31:0] data_memory_write_data;
    logic        data_memory_write_enable;
    logic        data_memory_read_enable;
    logic        UART_busy;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic [7:0]  mmio_uart_tx_data;
    logic        mmio_uart_tx_start;
    logic [31:0] mmio_read_data;
    logic        mmio_hit;

    modport master (
        output data_memory_address, data_memory_write_data,
               data_memory_write_enable, data_memory_read_enable,
               UART_busy, uart_rx_data, uart_rx_valid,
        input  mmio_uart_tx_data, mmio_uart_tx_start, mmio_read_data, mmio_hit
    );

    modport slave (
        input  data_memory_address, data_memory_write_data,
               data_memory_write_enable, data_memory_read_enable,
               UART_busy, uart_rx_data, uart_rx_valid,
        output mmio_uart_tx_data, mmio_uart_tx_start, mmio_read_data, mmio_hit
    );
endinterface

// File: rtl/mmio_uart_fifo_interface.sv
// MMIO bridge: CPU stores into a TX FIFO drained to the UART, RX bytes buffered for polling.
// Latency: loads are combinational; a pushed TX byte launches 1 cycle later when the UART is idle.
// Backpressure: none to the CPU; pushes into a full FIFO are dropped and set a sticky overflow flag.
//
// Ports: clk, reset_n (async active-low); bus (slave modport): CPU address/data/strobes,
// UART_busy, uart_rx_data/valid in; mmio_uart_tx_data/start, mmio_read_data, mmio_hit out.
module mmio_uart_fifo_interface #(
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter int          TX_DEPTH    = 8,
    parameter int          RX_DEPTH    = 8,
    parameter int          ACK_TIMEOUT = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    mmio_uart_fifo_interface_if.slave    bus
);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_LW = TX_AW + 1;
    localparam int RX_LW = RX_AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT_ACK, S_WAIT_DONE} state_t;

    // ---------------- address decode ----------------
    // Subtracting the base makes addresses below the window wrap to huge values,
    // so a single unsigned compare covers both window edges.
    logic [31:0] w_off;
    logic        w_hit;
    logic [1:0]  w_idx;
    logic        w_wr_tx, w_wr_ctrl, w_rd_rx;
    logic        w_unused;

    assign w_off     = bus.data_memory_address - BASE_ADDR;
    assign w_hit     = (w_off < 32'd16);
    assign w_idx     = w_off[3:2];
    assign w_wr_tx   = bus.data_memory_write_enable & w_hit & (w_idx == 2'd0);
    assign w_wr_ctrl = bus.data_memory_write_enable & w_hit & (w_idx == 2'd3);
    assign w_rd_rx   = bus.data_memory_read_enable  & w_hit & (w_idx == 2'd2);
    assign w_unused  = ^bus.data_memory_write_data[31:8];

    // ---------------- TX FIFO ----------------
    logic [7:0]       r_tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] r_tx_wptr, r_tx_rptr;
    logic [TX_LW-1:0] r_tx_level;
    logic             r_tx_ovf;
    logic             w_tx_empty, w_tx_full, w_tx_flush, w_tx_push_req, w_tx_push, w_tx_pop;

    assign w_tx_empty    = (r_tx_level == '0);
    assign w_tx_full     = (r_tx_level == TX_LW'(TX_DEPTH));
    assign w_tx_flush    = w_wr_ctrl & bus.data_memory_write_data[2];
    assign w_tx_push_req = w_wr_tx & ~w_tx_flush;
    assign w_tx_push     = w_tx_push_req & (~w_tx_full | w_tx_pop);

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wptr] <= bus.data_memory_write_data[7:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_wptr  <= '0;
            r_tx_rptr  <= '0;
            r_tx_level <= '0;
            r_tx_ovf   <= 1'b0;
        end else begin
            if (w_tx_flush) begin
                r_tx_wptr  <= '0;
                r_tx_rptr  <= '0;
                r_tx_level <= '0;
            end else begin
                if (w_tx_push) r_tx_wptr <= r_tx_wptr + TX_AW'(1);
                if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + TX_AW'(1);
                r_tx_level <= r_tx_level + TX_LW'(w_tx_push) - TX_LW'(w_tx_pop);
            end
            // a new overflow beats a same-cycle clear
            if (w_tx_push_req & w_tx_full & ~w_tx_pop) r_tx_ovf <= 1'b1;
            else if (w_wr_ctrl & bus.data_memory_write_data[0]) r_tx_ovf <= 1'b0;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]       r_rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] r_rx_wptr, r_rx_rptr;
    logic [RX_LW-1:0] r_rx_level;
    logic             r_rx_ovf;
    logic             w_rx_empty, w_rx_full, w_rx_flush, w_rx_push_req, w_rx_push, w_rx_pop;
    logic [7:0]       w_rx_head;

    assign w_rx_empty    = (r_rx_level == '0);
    assign w_rx_full     = (r_rx_level == RX_LW'(RX_DEPTH));
    assign w_rx_flush    = w_wr_ctrl & bus.data_memory_write_data[3];
    assign w_rx_push_req = bus.uart_rx_valid & ~w_rx_flush;
    // a load of an empty FIFO pops nothing, so a same-cycle push into empty survives
    assign w_rx_pop      = w_rd_rx & ~w_rx_empty;
    assign w_rx_push     = w_rx_push_req & (~w_rx_full | w_rx_pop);
    assign w_rx_head     = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rptr];

    always_ff @(posedge clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wptr] <= bus.uart_rx_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_rx_level <= '0;
            r_rx_ovf   <= 1'b0;
        end else begin
            if (w_rx_flush) begin
                r_rx_wptr  <= '0;
                r_rx_rptr  <= '0;
                r_rx_level <= '0;
            end else begin
                if (w_rx_push) r_rx_wptr <= r_rx_wptr + RX_AW'(1);
                if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + RX_AW'(1);
                r_rx_level <= r_rx_level + RX_LW'(w_rx_push) - RX_LW'(w_rx_pop);
            end
            if (w_rx_push_req & w_rx_full & ~w_rx_pop) r_rx_ovf <= 1'b1;
            else if (w_wr_ctrl & bus.data_memory_write_data[1]) r_rx_ovf <= 1'b0;
        end
    end

    // ---------------- TX handshake FSM ----------------
    state_t     r_state, w_state_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;
    logic [7:0] r_tx_data, w_tx_data_nxt;
    logic       r_tx_start, w_tx_start_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'h00;
            r_tx_data  <= 8'h00;
            r_tx_start <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_start <= w_tx_start_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_tx_data_nxt  = r_tx_data;
        w_tx_start_nxt = 1'b0;
        w_tx_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_tx_empty && !bus.UART_busy) begin
                    w_tx_data_nxt  = r_tx_mem[r_tx_rptr];
                    w_tx_start_nxt = 1'b1;
                    w_tx_pop       = 1'b1;
                    w_cnt_nxt      = 8'h00;
                    w_state_nxt    = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                // no ack within the window: treat the byte as sent and move on
                if (bus.UART_busy)                        w_state_nxt = S_WAIT_DONE;
                else if (r_cnt == 8'(ACK_TIMEOUT - 1))   w_state_nxt = S_IDLE;
                else                                      w_cnt_nxt   = r_cnt + 8'd1;
            end
            S_WAIT_DONE: begin
                if (!bus.UART_busy) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- load data / outputs ----------------
    logic [31:0] w_status, w_rdata;
    logic        w_tx_busy;

    assign w_tx_busy = (r_state != S_IDLE) | ~w_tx_empty;
    assign w_status  = {8'h00, 8'(r_rx_level), 8'(r_tx_level), 3'b000,
                        r_rx_ovf, r_tx_ovf, ~w_rx_empty, w_tx_full, w_tx_busy};

    always_comb begin
        w_rdata = 32'h0;
        if (w_hit) begin
            case (w_idx)
                2'd1:    w_rdata = w_status;
                2'd2:    w_rdata = {24'h0, w_rx_head};
                default: w_rdata = 32'h0;
            endcase
        end
    end

    assign bus.mmio_read_data     = w_rdata;
    assign bus.mmio_hit           = w_hit;
    assign bus.mmio_uart_tx_data  = r_tx_data;
    assign bus.mmio_uart_tx_start = r_tx_start;
endmodule

// File: tb/tb_mmio_uart_fifo_interface.sv
// Directed bench for the MMIO UART bridge: register map, TX drain order, overflow,
// RX polling, ack timeout and asynchronous reset mid-transfer.
// A small UART model answers start pulses; checks are immediate assertions.
module tb_mmio_uart_fifo_interface;
    localparam logic [31:0] BASE = 32'h1001_0000;
    localparam logic [31:0] A_TX = BASE;
    localparam logic [31:0] A_ST = BASE + 32'h4;
    localparam logic [31:0] A_RX = BASE + 32'h8;
    localparam logic [31:0] A_CT = BASE + 32'hC;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mmio_uart_fifo_interface_if bus();

    mmio_uart_fifo_interface #(
        .BASE_ADDR(BASE), .TX_DEPTH(8), .RX_DEPTH(8), .ACK_TIMEOUT(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // UART model: mode 0 = busy rises one cycle after start for 10 cycles,
    // mode 1 = busy held high, mode 2 = busy never rises.
    int         uart_mode = 0;
    int         busy_cnt = 0;
    bit         pend = 0;
    bit         prev_start = 0;
    int         wide_err = 0;
    logic [7:0] starts[$];
    int         start_cyc[$];

    always @(negedge clk) begin
        if (bus.mmio_uart_tx_start === 1'b1) begin
            starts.push_back(bus.mmio_uart_tx_data);
            start_cyc.push_back(cyc);
            if (prev_start) wide_err++;
        end
        prev_start = (bus.mmio_uart_tx_start === 1'b1);
        case (uart_mode)
            1: begin bus.UART_busy = 1'b1; pend = 0; busy_cnt = 0; end
            2: begin bus.UART_busy = 1'b0; pend = 0; busy_cnt = 0; end
            default: begin
                if (pend) begin pend = 0; busy_cnt = 10; end
                else if (busy_cnt > 0) busy_cnt--;
                bus.UART_busy = (busy_cnt != 0);
                pend = (bus.mmio_uart_tx_start === 1'b1);
            end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.data_memory_address      = a;
        bus.data_memory_write_data   = d;
        bus.data_memory_write_enable = 1'b1;
        @(negedge clk);
        bus.data_memory_write_enable = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.data_memory_address     = a;
        bus.data_memory_read_enable = 1'b1;
        #1 d = bus.mmio_read_data;
        @(negedge clk);
        bus.data_memory_read_enable = 1'b0;
    endtask

    task automatic rx_push(input logic [7:0] b);
        @(negedge clk);
        bus.uart_rx_data  = b;
        bus.uart_rx_valid = 1'b1;
        @(negedge clk);
        bus.uart_rx_valid = 1'b0;
    endtask

    // Poll STATUS until it reads 0 with n start pulses seen, bounded.
    task automatic drain(input int n);
        logic [31:0] s;
        for (int i = 0; i < 300; i++) begin
            rd(A_ST, s);
            if (s == 32'h0 && starts.size() == n) break;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        reset_n = 1'b0;
        bus.data_memory_address      = '0;
        bus.data_memory_write_data   = '0;
        bus.data_memory_write_enable = 1'b0;
        bus.data_memory_read_enable  = 1'b0;
        bus.uart_rx_data             = '0;
        bus.uart_rx_valid            = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_start", {31'h0, bus.mmio_uart_tx_start}, 32'h0);
        check("rst_tx_data", {24'h0, bus.mmio_uart_tx_data}, 32'h0);
        reset_n = 1'b1;

        // reset state and decode
        rd(A_ST, d);                         check("status_after_reset", d, 32'h0);
        @(negedge clk);
        bus.data_memory_address = A_ST;      #1 check("hit_base4", {31'h0, bus.mmio_hit}, 32'h1);
        bus.data_memory_address = BASE + 32'h10;
        #1 check("hit_base10", {31'h0, bus.mmio_hit}, 32'h0);
        check("rdata_outside", bus.mmio_read_data, 32'h0);
        bus.data_memory_address = BASE - 32'h4;
        #1 check("hit_below", {31'h0, bus.mmio_hit}, 32'h0);
        repeat (5) @(negedge clk);
        check("no_start_idle", starts.size(), 0);

        // three bytes, held until the UART model is released
        uart_mode = 1;
        repeat (2) @(negedge clk);
        wr(A_TX, 32'h41); wr(A_TX, 32'h42); wr(A_TX, 32'h43);
        rd(A_ST, d);                         check("status_tx3", d, 32'h0000_0301);
        uart_mode = 0;
        drain(3);
        check("tx3_count", starts.size(), 3);
        check("tx3_b0", {24'h0, starts[0]}, 32'h41);
        check("tx3_b1", {24'h0, starts[1]}, 32'h42);
        check("tx3_b2", {24'h0, starts[2]}, 32'h43);
        rd(A_ST, d);                         check("status_drained", d, 32'h0);

        // TX overflow: 9 writes into 8 entries while UART is busy
        starts.delete(); start_cyc.delete();
        uart_mode = 1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 9; i++) wr(A_TX, 32'h10 + i);
        rd(A_ST, d);                         check("status_tx_full_ovf", d, 32'h0000_080B);
        wr(A_CT, 32'h1);
        rd(A_ST, d);                         check("status_tx_ovf_clr", d, 32'h0000_0803);
        uart_mode = 0;
        drain(8);
        check("ovf_count", starts.size(), 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("ovf_b%0d", i), {24'h0, starts[i]}, 32'h10 + i);

        // TX flush
        uart_mode = 1;
        repeat (2) @(negedge clk);
        wr(A_TX, 32'hEE); wr(A_TX, 32'hEF);
        rd(A_ST, d);                         check("status_tx2", d, 32'h0000_0201);
        wr(A_CT, 32'h4);
        rd(A_ST, d);                         check("status_tx_flushed", d, 32'h0);

        // RX polling
        rx_push(8'h5A); rx_push(8'hA5);
        rd(A_ST, d);                         check("status_rx2", d, 32'h0002_0004);
        rd(A_RX, d);                         check("rx_pop0", d, 32'h5A);
        rd(A_RX, d);                         check("rx_pop1", d, 32'hA5);
        rd(A_RX, d);                         check("rx_pop_empty", d, 32'h0);
        rd(A_ST, d);                         check("status_rx_empty", d, 32'h0);

        // RX full with simultaneous push and pop
        for (int i = 0; i < 8; i++) rx_push(8'h80 + 8'(i));
        rd(A_ST, d);                         check("status_rx_full", d, 32'h0008_0004);
        @(negedge clk);
        bus.data_memory_address     = A_RX;
        bus.data_memory_read_enable = 1'b1;
        bus.uart_rx_data            = 8'h99;
        bus.uart_rx_valid           = 1'b1;
        #1 d = bus.mmio_read_data;
        @(negedge clk);
        bus.data_memory_read_enable = 1'b0;
        bus.uart_rx_valid           = 1'b0;
        check("rx_pushpop_head", d, 32'h80);
        rd(A_ST, d);                         check("status_rx_pushpop", d, 32'h0008_0004);
        for (int i = 0; i < 8; i++) begin
            rd(A_RX, d);
            check($sformatf("rx_order%0d", i), d, (i < 7) ? 32'h81 + i : 32'h99);
        end

        // RX overflow, clear, flush
        for (int i = 0; i < 9; i++) rx_push(8'hC0 + 8'(i));
        rd(A_ST, d);                         check("status_rx_ovf", d, 32'h0008_0014);
        wr(A_CT, 32'h2);
        rd(A_ST, d);                         check("status_rx_ovf_clr", d, 32'h0008_0004);
        wr(A_CT, 32'h8);
        rd(A_ST, d);                         check("status_rx_flushed", d, 32'h0);

        // ack timeout: busy never rises
        starts.delete(); start_cyc.delete();
        uart_mode = 2;
        repeat (2) @(negedge clk);
        wr(A_TX, 32'h61); wr(A_TX, 32'h62);
        for (int i = 0; i < 60 && starts.size() < 2; i++) @(negedge clk);
        check("to_count", starts.size(), 2);
        check("to_b0", {24'h0, starts[0]}, 32'h61);
        check("to_b1", {24'h0, starts[1]}, 32'h62);
        check("to_gap", start_cyc[1] - start_cyc[0], 5);

        // asynchronous reset while waiting for the UART to finish
        repeat (10) @(negedge clk);
        starts.delete(); start_cyc.delete();
        uart_mode = 0;
        repeat (2) @(negedge clk);
        wr(A_TX, 32'h71); wr(A_TX, 32'h72); wr(A_TX, 32'h73);
        for (int i = 0; i < 60 && !(starts.size() >= 1 && bus.UART_busy === 1'b1); i++)
            @(negedge clk);
        repeat (3) @(negedge clk);
        check("pre_rst_tx_data", {24'h0, bus.mmio_uart_tx_data}, 32'h71);
        bus.data_memory_address = A_ST;
        #2 reset_n = 1'b0;
        #1;
        check("arst_tx_start", {31'h0, bus.mmio_uart_tx_start}, 32'h0);
        check("arst_tx_data", {24'h0, bus.mmio_uart_tx_data}, 32'h0);
        check("arst_status", bus.mmio_read_data, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        check("post_rst_starts", starts.size(), 1);
        rd(A_ST, d);                         check("post_rst_status", d, 32'h0);
        check("start_pulse_width", wide_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
